// File: rtl/screensaver_pkg.sv
// Shared definitions for the screensaver display path: screen geometry
// (shared with the VGA timer), sprite position/speed widths, the motion
// FSM state encoding and the direction encoding used by each axis.
package screensaver_pkg;

  localparam int SCREEN_W_DEF = 640;
  localparam int SCREEN_H_DEF = 480;

  localparam int POS_W = 10;
  localparam int SPD_W = 3;

  typedef enum logic [1:0] {
    WAIT_VS = 2'd0,
    STEP_X  = 2'd1,
    STEP_Y  = 2'd2
  } step_state_e;

  typedef enum logic {
    DIR_POS = 1'b0,
    DIR_NEG = 1'b1
  } dir_e;

endpackage

// File: rtl/sprite_motion_ctrl_if.sv
// Per-axis step bundle between the motion controller and an axis_step.
//   master (controller): drives current position, direction, latched speed
//   slave  (axis_step) : returns next position, next direction, reflection flag
interface sprite_motion_ctrl_if;
  import screensaver_pkg::*;

  logic [POS_W-1:0] pos;
  dir_e             dir;
  logic [SPD_W-1:0] speed;
  logic [POS_W-1:0] nxt_pos;
  dir_e             nxt_dir;
  logic             refl;

  modport master (output pos, dir, speed, input nxt_pos, nxt_dir, refl);
  modport slave  (input pos, dir, speed, output nxt_pos, nxt_dir, refl);

endinterface

// File: rtl/axis_step.sv
// One axis of sprite motion: given position, direction and step size, produce
// the position/direction after one step and flag an edge reflection.
// Purely combinational; the controller decides when to commit the result.
//   MAX : largest legal position on this axis (screen size minus sprite size)
//   ax  : slave side of the per-axis step bundle
module axis_step
  import screensaver_pkg::*;
#(
  parameter int MAX = 576
) (
  sprite_motion_ctrl_if.slave ax
);

  localparam logic [POS_W:0] MAX_C = (POS_W + 1)'(MAX);

  // One extra bit so pos+speed near the bound cannot wrap.
  logic [POS_W:0] pos_w;
  logic [POS_W:0] spd_w;
  logic [POS_W:0] sum_w;
  logic [POS_W:0] diff_w;

  always_comb begin
    pos_w  = {1'b0, ax.pos};
    spd_w  = {{(POS_W + 1 - SPD_W){1'b0}}, ax.speed};
    sum_w  = pos_w + spd_w;
    diff_w = pos_w - spd_w;

    ax.nxt_pos = ax.pos;
    ax.nxt_dir = ax.dir;
    ax.refl    = 1'b0;

    // A zero step is a freeze: no motion and no reflection even at a bound.
    if (ax.speed != '0) begin
      if (ax.dir == DIR_POS) begin
        if (sum_w >= MAX_C) begin
          ax.nxt_pos = POS_W'(MAX_C);
          ax.nxt_dir = DIR_NEG;
          ax.refl    = 1'b1;
        end else begin
          ax.nxt_pos = POS_W'(sum_w);
        end
      end else begin
        if (pos_w <= spd_w) begin
          ax.nxt_pos = '0;
          ax.nxt_dir = DIR_POS;
          ax.refl    = 1'b1;
        end else begin
          ax.nxt_pos = POS_W'(diff_w);
        end
      end
    end
  end

endmodule

// File: rtl/sprite_motion_ctrl.sv
// Bouncing-sprite motion controller for a VGA screensaver.
// Detects vsync rising edges, divides them down to motion steps, and on each
// step moves the sprite box one x-step then one y-step, reflecting off the
// screen edges. Also flags when the current scan pixel lies inside the box.
// Ports:
//   clk_i, rst_ni              pixel clock, async active-low reset
//   vsync_i, visible_i         timing from the VGA timer
//   position_x_i/_y_i          current scan pixel
//   enable_i, speed_i          motion enable, pixels per step per axis
//   sprite_x_o/_y_o            sprite top-left corner
//   sprite_hit_o               registered in-box flag for the scan pixel
//   bounce_o, frame_o          one-cycle pulses: reflection, frame event
module sprite_motion_ctrl
  import screensaver_pkg::*;
#(
  parameter int SCREEN_W        = SCREEN_W_DEF,
  parameter int SCREEN_H        = SCREEN_H_DEF,
  parameter int SPRITE_W        = 64,
  parameter int SPRITE_H        = 32,
  parameter int FRAMES_PER_STEP = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             vsync_i,
  input  logic             visible_i,
  input  logic [POS_W-1:0] position_x_i,
  input  logic [POS_W-1:0] position_y_i,
  input  logic             enable_i,
  input  logic [SPD_W-1:0] speed_i,
  output logic [POS_W-1:0] sprite_x_o,
  output logic [POS_W-1:0] sprite_y_o,
  output logic             sprite_hit_o,
  output logic             bounce_o,
  output logic             frame_o
);

  localparam int          XMAX     = SCREEN_W - SPRITE_W;
  localparam int          YMAX     = SCREEN_H - SPRITE_H;
  localparam logic [7:0]  DIV_LAST = 8'(FRAMES_PER_STEP - 1);

  step_state_e      state_q, state_d;
  logic             vs_q;
  logic             frame_q, frame_d;
  logic [7:0]       div_q, div_d;
  logic [SPD_W-1:0] spd_q, spd_d;
  logic [POS_W-1:0] x_q, x_d, y_q, y_d;
  dir_e             dirx_q, dirx_d, diry_q, diry_d;
  logic             bounce_q, bounce_d;
  logic             hit_q, hit_d;
  logic             sched;
  logic [POS_W:0]   x_end, y_end;

  sprite_motion_ctrl_if ax_x ();
  sprite_motion_ctrl_if ax_y ();

  assign ax_x.pos   = x_q;
  assign ax_x.dir   = dirx_q;
  assign ax_x.speed = spd_q;
  assign ax_y.pos   = y_q;
  assign ax_y.dir   = diry_q;
  assign ax_y.speed = spd_q;

  axis_step #(.MAX(XMAX)) u_step_x (.ax(ax_x));
  axis_step #(.MAX(YMAX)) u_step_y (.ax(ax_y));

  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    spd_d    = spd_q;
    x_d      = x_q;
    y_d      = y_q;
    dirx_d   = dirx_q;
    diry_d   = diry_q;
    bounce_d = 1'b0;

    frame_d = vsync_i & ~vs_q;
    sched   = frame_d && (div_q == DIV_LAST);

    // Divider runs on every frame event, independent of enable_i.
    if (frame_d) begin
      div_d = sched ? 8'd0 : div_q + 8'd1;
    end

    unique case (state_q)
      WAIT_VS: begin
        if (sched && enable_i) begin
          state_d = STEP_X;
          spd_d   = speed_i;
        end
      end
      STEP_X: begin
        x_d      = ax_x.nxt_pos;
        dirx_d   = ax_x.nxt_dir;
        bounce_d = ax_x.refl;
        state_d  = STEP_Y;
      end
      STEP_Y: begin
        y_d      = ax_y.nxt_pos;
        diry_d   = ax_y.nxt_dir;
        bounce_d = ax_y.refl;
        state_d  = WAIT_VS;
      end
      default: state_d = WAIT_VS;
    endcase

    // Box right/bottom edges in 11 bits so a box near the limit cannot wrap.
    x_end = {1'b0, x_q} + (POS_W + 1)'(SPRITE_W);
    y_end = {1'b0, y_q} + (POS_W + 1)'(SPRITE_H);
    hit_d = visible_i
         && (position_x_i >= x_q) && ({1'b0, position_x_i} < x_end)
         && (position_y_i >= y_q) && ({1'b0, position_y_i} < y_end);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= WAIT_VS;
      vs_q     <= 1'b0;
      frame_q  <= 1'b0;
      div_q    <= 8'd0;
      x_q      <= '0;
      y_q      <= '0;
      dirx_q   <= DIR_POS;
      diry_q   <= DIR_POS;
      bounce_q <= 1'b0;
      hit_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      vs_q     <= vsync_i;
      frame_q  <= frame_d;
      div_q    <= div_d;
      x_q      <= x_d;
      y_q      <= y_d;
      dirx_q   <= dirx_d;
      diry_q   <= diry_d;
      bounce_q <= bounce_d;
      hit_q    <= hit_d;
    end
  end

  // Step size is only meaningful while a step is in flight; no reset needed.
  always_ff @(posedge clk_i) begin
    spd_q <= spd_d;
  end

  assign sprite_x_o   = x_q;
  assign sprite_y_o   = y_q;
  assign sprite_hit_o = hit_q;
  assign bounce_o     = bounce_q;
  assign frame_o      = frame_q;

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// Directed bench for sprite_motion_ctrl. Three instances share the stimulus:
// default geometry, FRAMES_PER_STEP=4, and a tiny screen (XMAX=6, YMAX=5)
// that reaches both edges within a few steps.
module tb_sprite_motion_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       vsync = 1'b0;
  logic       visible = 1'b0;
  logic [9:0] px = '0;
  logic [9:0] py = '0;
  logic       en = 1'b0;
  logic [2:0] spd = '0;

  logic [9:0] x0, y0, x4, y4, xs, ys;
  logic       hit0, bnc0, frm0, hit4, bnc4, frm4, hits, bncs, frms;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int b0_cnt = 0;
  int f0_cnt = 0;
  int bs_cnt = 0;
  int bs_last = 0;
  int bs_prev = 0;
  int snap_b, snap_f;

  always #5 clk = ~clk;

  sprite_motion_ctrl dut (
    .clk_i(clk), .rst_ni(rst_n), .vsync_i(vsync), .visible_i(visible),
    .position_x_i(px), .position_y_i(py), .enable_i(en), .speed_i(spd),
    .sprite_x_o(x0), .sprite_y_o(y0), .sprite_hit_o(hit0),
    .bounce_o(bnc0), .frame_o(frm0));

  sprite_motion_ctrl #(.FRAMES_PER_STEP(4)) dut4 (
    .clk_i(clk), .rst_ni(rst_n), .vsync_i(vsync), .visible_i(visible),
    .position_x_i(px), .position_y_i(py), .enable_i(en), .speed_i(spd),
    .sprite_x_o(x4), .sprite_y_o(y4), .sprite_hit_o(hit4),
    .bounce_o(bnc4), .frame_o(frm4));

  sprite_motion_ctrl #(.SCREEN_W(70), .SCREEN_H(37)) duts (
    .clk_i(clk), .rst_ni(rst_n), .vsync_i(vsync), .visible_i(visible),
    .position_x_i(px), .position_y_i(py), .enable_i(en), .speed_i(spd),
    .sprite_x_o(xs), .sprite_y_o(ys), .sprite_hit_o(hits),
    .bounce_o(bncs), .frame_o(frms));

  // Pulse counters, sampled on the falling edge.
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (bnc0) b0_cnt <= b0_cnt + 1;
    if (frm0) f0_cnt <= f0_cnt + 1;
    if (bncs) begin
      bs_cnt  <= bs_cnt + 1;
      bs_prev <= bs_last;
      bs_last <= cyc;
    end
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic vs_edge();
    @(negedge clk);
    vsync = 1'b1;
    repeat (4) @(negedge clk);
    vsync = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic vs_edges(input int n);
    for (int i = 0; i < n; i++) vs_edge();
  endtask

  task automatic probe(input string tag, input int x, input int y,
                       input logic vis, input int exp);
    @(negedge clk);
    px = 10'(x);
    py = 10'(y);
    visible = vis;
    @(negedge clk);
    chk(tag, int'(hit0), exp);
  endtask

  initial begin
    // Reset state of every instance
    repeat (2) @(negedge clk);
    chk("rst_x0", x0, 0);     chk("rst_y0", y0, 0);
    chk("rst_hit0", hit0, 0); chk("rst_bnc0", bnc0, 0); chk("rst_frm0", frm0, 0);
    chk("rst_x4", x4, 0);     chk("rst_y4", y4, 0);
    chk("rst_hit4", hit4, 0); chk("rst_bnc4", bnc4, 0); chk("rst_frm4", frm4, 0);
    chk("rst_xs", xs, 0);     chk("rst_ys", ys, 0);
    chk("rst_hits", hits, 0); chk("rst_bncs", bncs, 0); chk("rst_frms", frms, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Five steps of 3 from the origin
    en = 1'b1;
    spd = 3'd3;
    snap_b = b0_cnt;
    snap_f = f0_cnt;
    vs_edges(5);
    chk("basic_x", x0, 15);
    chk("basic_y", y0, 15);
    chk("basic_bounces", b0_cnt - snap_b, 0);
    chk("basic_frames", f0_cnt - snap_f, 5);
    chk("div4_after5_x", x4, 3);
    chk("div4_after5_y", y4, 3);

    // Hit window of the 64x32 box at (15,15)
    probe("hit_left_out", 14, 15, 1'b1, 0);
    probe("hit_corner_in", 15, 15, 1'b1, 1);
    probe("hit_far_in", 78, 46, 1'b1, 1);
    probe("hit_right_out", 79, 46, 1'b1, 0);
    probe("hit_below_out", 15, 47, 1'b1, 0);
    probe("hit_invisible", 15, 15, 1'b0, 0);

    // Frame divider by 4, including edges seen while disabled
    do_reset();
    spd = 3'd1;
    en = 1'b1;
    vs_edges(8);
    chk("div4_x", x4, 2);
    chk("div4_y", y4, 2);
    en = 1'b0;
    vs_edges(4);
    chk("div4_dis_x", x4, 2);
    chk("div4_dis_y", y4, 2);
    vs_edges(2);
    en = 1'b1;
    vs_edges(2);
    chk("div4_counts_disabled_x", x4, 3);
    chk("div4_counts_disabled_y", y4, 3);

    // Right-edge reflection on the default screen
    do_reset();
    spd = 3'd7;
    vs_edges(82);
    chk("approach_x", x0, 574);
    chk("approach_y", y0, 322);
    spd = 3'd3;
    snap_b = b0_cnt;
    vs_edge();
    chk("right_bounce_x", x0, 576);
    chk("right_bounce_y", y0, 319);
    chk("right_bounce_cnt", b0_cnt - snap_b, 1);
    vs_edge();
    chk("after_bounce_x", x0, 573);
    chk("after_bounce_y", y0, 316);

    // Tiny screen: both axes reflect at the far edges, then at zero
    do_reset();
    spd = 3'd3;
    vs_edges(2);
    chk("small_far_x", xs, 6);
    chk("small_far_y", ys, 5);
    spd = 3'd4;
    vs_edge();
    chk("small_down_x", xs, 2);
    chk("small_down_y", ys, 1);
    snap_b = bs_cnt;
    vs_edge();
    chk("small_zero_x", xs, 0);
    chk("small_zero_y", ys, 0);
    chk("small_zero_bounces", bs_cnt - snap_b, 2);
    chk("small_bounce_gap", bs_last - bs_prev, 1);
    vs_edge();
    chk("small_up_x", xs, 4);
    chk("small_up_y", ys, 4);
    spd = 3'd0;
    snap_b = bs_cnt;
    vs_edge();
    chk("frozen_x", xs, 4);
    chk("frozen_y", ys, 4);
    chk("frozen_bounces", bs_cnt - snap_b, 0);
    chk("pre_rst_x", x0, 18);
    chk("pre_rst_y", y0, 18);

    // Reset asserted while the step is in STEP_X
    spd = 3'd3;
    @(negedge clk);
    vsync = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_x", x0, 0);
    chk("midrst_y", y0, 0);
    chk("midrst_frame", frm0, 0);
    chk("midrst_bounce", bnc0, 0);
    chk("midrst_hit", hit0, 0);
    @(negedge clk);
    vsync = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("midrst_discard_x", x0, 0);
    snap_f = f0_cnt;
    vs_edge();
    chk("postrst_frames", f0_cnt - snap_f, 1);
    chk("postrst_x", x0, 3);
    chk("postrst_y", y0, 3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/sprite_motion_ctrl.md
SPRITE_MOTION_CTRL -- requirements
Module: sprite_motion_ctrl

Interface
REQ-001 SHALL have parameter SCREEN_W, default 640: visible width in pixels.
REQ-002 SHALL have parameter SCREEN_H, default 480: visible height in pixels.
REQ-003 SHALL have parameter SPRITE_W, default 64: sprite box width.
REQ-004 SHALL have parameter SPRITE_H, default 32: sprite box height.
REQ-005 SHALL have parameter FRAMES_PER_STEP, default 1: frames per motion step, range 1..255.
REQ-006 SHALL have port clk_i  input  1  pixel clock; the design has one clock.
REQ-007 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-008 SHALL have port vsync_i  input  1  vertical sync from the VGA timer, active-high.
REQ-009 SHALL have port visible_i  input  1  active-video flag from the timer.
REQ-010 SHALL have port position_x_i  input  10  current pixel column.
REQ-011 SHALL have port position_y_i  input  10  current pixel row.
REQ-012 SHALL have port enable_i  input  1  motion enable.
REQ-013 SHALL have port speed_i  input  3  step size in pixels per axis; 0 means frozen.
REQ-014 SHALL have port sprite_x_o  output  10  sprite left edge.
REQ-015 SHALL have port sprite_y_o  output  10  sprite top edge.
REQ-016 SHALL have port sprite_hit_o  output  1  current pixel lies inside the sprite box.
REQ-017 SHALL have port bounce_o  output  1  one-cycle pulse on any edge reflection.
REQ-018 SHALL have port frame_o  output  1  one-cycle pulse on each detected vsync rising edge.

Function
REQ-019 Frame event SHALL be vsync_i registered value 0 with current value 1; frame_o SHALL assert the cycle after the edge.
REQ-020 An 8-bit frame divider SHALL count frame events; a step SHALL be scheduled when the count reaches FRAMES_PER_STEP-1, after which the divider SHALL return to 0.
REQ-021 FSM states SHALL be WAIT_VS, STEP_X, STEP_Y.
- WAIT_VS -> STEP_X: scheduled step and enable_i=1.
- STEP_X -> STEP_Y: unconditional.
- STEP_Y -> WAIT_VS: unconditional.
REQ-022 speed_i SHALL be captured on the WAIT_VS->STEP_X transition and held for the whole step.
REQ-023 XMAX SHALL be SCREEN_W-SPRITE_W (576 at defaults); YMAX SHALL be SCREEN_H-SPRITE_H (448 at defaults).
REQ-024 Step arithmetic SHALL use 11-bit unsigned intermediates with no 10-bit wrap.
REQ-025 STEP_X, dir_x=+:
- If x+speed >= XMAX: x<=XMAX, dir_x<=-, bounce.
- Otherwise: x<=x+speed.
REQ-026 STEP_X, dir_x=-:
- If x <= speed: x<=0, dir_x<=+, bounce.
- Otherwise: x<=x-speed.
REQ-027 STEP_Y SHALL apply the same rules as REQ-025/026 to y, dir_y and YMAX.
REQ-028 With speed=0, no position change and no bounce SHALL occur, even at a bound.
REQ-029 bounce_o SHALL pulse one cycle after STEP_X or STEP_Y reflects; a reflection on both axes SHALL give two separate pulses.
REQ-030 enable_i SHALL be examined only in WAIT_VS; deasserting it mid-step SHALL NOT abort the step.
REQ-031 The frame divider SHALL count whether enable_i is high or low.
REQ-032 sprite_hit_o SHALL be registered with 1-cycle latency and equal:
- visible_i, and
- sprite_x_o <= position_x_i < sprite_x_o+SPRITE_W, and
- sprite_y_o <= position_y_i < sprite_y_o+SPRITE_H.
REQ-033 sprite_x_o and sprite_y_o SHALL change only in STEP_X and STEP_Y.

Reset
REQ-034 On rst_ni=0, asynchronously:
- FSM=WAIT_VS, divider=0, dir_x=+, dir_y=+.
- sprite_x_o=0, sprite_y_o=0.
- sprite_hit_o=0, bounce_o=0, frame_o=0.
- vsync history=0.
REQ-035 Reset asserted mid-step SHALL discard the step; the first frame event after release SHALL NOT be lost.

Structure
REQ-036 Shared package screensaver_pkg SHALL hold the FSM state enum and the 640/480 screen constants, shared with the VGA timer.
REQ-037 One sub-module axis_step SHALL hold the per-axis next-position/direction/bounce logic, instantiated once for x and once for y.

Verification
REQ-038 Defaults, enable=1, speed=3, 5 vsync edges -> sprite at (15,15), no bounce_o, five frame_o pulses.
REQ-039 x=574, dir_x=+, speed=3, one step -> x=576, dir_x=-, one bounce_o pulse; next step -> x=573.
REQ-040 x=2, y=1, both dirs -, speed=4, one step -> (0,0), both dirs +, two bounce_o pulses one cycle apart.
REQ-041 FRAMES_PER_STEP=4, speed=1, 8 vsync edges -> x=2, y=2; enable=0 for a further 4 edges -> position unchanged.
REQ-042 Sprite at (100,50), scan pixels (99,50), (100,50), (163,81), (164,81) with visible=1 -> sprite_hit_o=0,1,1,0 one cycle later; visible=0 at (100,50) -> 0.
REQ-043 rst_ni pulsed low during STEP_X -> all outputs at reset values immediately; next vsync edge after release -> frame_o pulses and the step runs normally.
